// File: rtl/pipe_ctrl_pkg.sv
// Shared types for the pipeline sequencing controller: FSM states, scoreboard
// entry layout and the vector iteration count helper.
package pipe_ctrl_pkg;

  // Entry address fields are sized to hold any supported register address width.
  localparam int SB_ADDR_W = 8;

  typedef enum logic {RUN = 1'b0, VBUSY = 1'b1} state_e;

  typedef enum logic [1:0] {
    SB_LOAD    = 2'd0,  // M <- E, E <- decode
    SB_ADVANCE = 2'd1,  // M <- E, E <- empty
    SB_HOLD    = 2'd2   // E held, M <- empty
  } sb_op_e;

  typedef struct packed {
    logic                 valid;
    logic                 wrS;
    logic [SB_ADDR_W-1:0] dstS;
    logic                 wrV;
    logic [SB_ADDR_W-1:0] dstV;
    logic                 vecOp;
  } sb_entry_t;

  function automatic int calc_n(input int size, input int lanes);
    return (size + lanes - 1) / lanes;
  endfunction

endpackage

// File: rtl/pipe_scoreboard.sv
// Two-entry in-flight destination tracker (Execute, Memory) with a
// combinational read-after-write hit against the instruction in Decode.
module pipe_scoreboard
  import pipe_ctrl_pkg::*;
#(
  parameter int REGI_BITS = 4,
  parameter int VECT_BITS = 2
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  sb_op_e               i_op,
  input  sb_entry_t            i_dec,
  input  logic [REGI_BITS-1:0] i_srcS1,
  input  logic [REGI_BITS-1:0] i_srcS2,
  input  logic [1:0]           i_useS,
  input  logic [VECT_BITS-1:0] i_srcV1,
  input  logic [VECT_BITS-1:0] i_srcV2,
  input  logic [1:0]           i_useV,
  output logic                 o_e_valid,
  output logic                 o_e_vecOp,
  output logic                 o_raw
);

  sb_entry_t            r_e, r_m;
  logic [3:0]           w_use;
  logic [SB_ADDR_W-1:0] w_s1, w_s2, w_v1, w_v2;

  assign w_use = {i_useV, i_useS};
  assign w_s1  = SB_ADDR_W'(i_srcS1);
  assign w_s2  = SB_ADDR_W'(i_srcS2);
  assign w_v1  = SB_ADDR_W'(i_srcV1);
  assign w_v2  = SB_ADDR_W'(i_srcV2);

  // Scalar sources only ever meet scalar destinations, vector only vector.
  function automatic logic hit(input sb_entry_t ent, input logic [3:0] use_f,
                               input logic [SB_ADDR_W-1:0] s1, input logic [SB_ADDR_W-1:0] s2,
                               input logic [SB_ADDR_W-1:0] v1, input logic [SB_ADDR_W-1:0] v2);
    hit = ent.valid & ((use_f[0] & ent.wrS & (s1 == ent.dstS)) |
                       (use_f[1] & ent.wrS & (s2 == ent.dstS)) |
                       (use_f[2] & ent.wrV & (v1 == ent.dstV)) |
                       (use_f[3] & ent.wrV & (v2 == ent.dstV)));
  endfunction

  assign o_raw = i_dec.valid & (hit(r_e, w_use, w_s1, w_s2, w_v1, w_v2) |
                                hit(r_m, w_use, w_s1, w_s2, w_v1, w_v2));
  assign o_e_valid = r_e.valid;
  assign o_e_vecOp = r_e.vecOp;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_e <= '0;
      r_m <= '0;
    end else begin
      case (i_op)
        SB_HOLD:    r_m <= '0;
        SB_ADVANCE: begin
          r_m <= r_e;
          r_e <= '0;
        end
        default: begin
          r_m <= r_e;
          r_e <= i_dec;
        end
      endcase
    end
  end

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Stage enable/flush sequencing for the 4-stage pipeline: branch squash,
// vector iteration hold in Execute and RAW stall, in that priority.
module pipe_hazard_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int REGI_BITS  = 4,
  parameter int VECT_BITS  = 2,
  parameter int VECT_LANES = 3,
  parameter int VECT_SIZE  = 8
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 decValid_i,
  input  logic [REGI_BITS-1:0] decSrcS1_i,
  input  logic [REGI_BITS-1:0] decSrcS2_i,
  input  logic [1:0]           decUseS_i,
  input  logic [VECT_BITS-1:0] decSrcV1_i,
  input  logic [VECT_BITS-1:0] decSrcV2_i,
  input  logic [1:0]           decUseV_i,
  input  logic [REGI_BITS-1:0] decDstS_i,
  input  logic                 decWrS_i,
  input  logic [VECT_BITS-1:0] decDstV_i,
  input  logic                 decWrV_i,
  input  logic                 decVecOp_i,
  input  logic                 branchTaken_i,
  output logic                 fdEn_o,
  output logic                 deEn_o,
  output logic                 emEn_o,
  output logic                 mwEn_o,
  output logic                 fdFlush_o,
  output logic                 deFlush_o,
  output logic                 emFlush_o,
  output logic [2:0]           exIter_o,
  output logic                 exLast_o,
  output logic                 stall_o
);

  localparam int         N    = calc_n(VECT_SIZE, VECT_LANES);
  localparam logic [2:0] LAST = 3'(N - 1);

  state_e     r_state, w_state_nxt;
  logic [2:0] r_iter, w_iter_nxt;
  sb_entry_t  w_dec;
  sb_op_e     w_op;
  logic       w_raw, w_e_valid, w_e_vecOp, w_branch, w_vbusy, w_last;
  logic       w_fdEn, w_deEn, w_emEn, w_mwEn, w_fdFl, w_deFl, w_emFl;

  assign w_dec = '{valid: decValid_i, wrS: decWrS_i, dstS: SB_ADDR_W'(decDstS_i),
                   wrV: decWrV_i, dstV: SB_ADDR_W'(decDstV_i), vecOp: decVecOp_i};

  pipe_scoreboard #(.REGI_BITS(REGI_BITS), .VECT_BITS(VECT_BITS)) u_sb (
    .clk_i     (clk_i),
    .rst_i     (rst_i),
    .i_op      (w_op),
    .i_dec     (w_dec),
    .i_srcS1   (decSrcS1_i),
    .i_srcS2   (decSrcS2_i),
    .i_useS    (decUseS_i),
    .i_srcV1   (decSrcV1_i),
    .i_srcV2   (decSrcV2_i),
    .i_useV    (decUseV_i),
    .o_e_valid (w_e_valid),
    .o_e_vecOp (w_e_vecOp),
    .o_raw     (w_raw)
  );

  // A vector op cannot redirect, so a branch flag alongside one is ignored.
  assign w_branch = branchTaken_i & w_e_valid & ~w_e_vecOp;
  assign w_vbusy  = (r_state == VBUSY) && (r_iter != LAST);
  assign w_last   = w_e_valid & (~w_e_vecOp | (r_iter == LAST));

  always_comb begin
    w_fdEn      = 1'b1;
    w_deEn      = 1'b1;
    w_emEn      = 1'b1;
    w_mwEn      = 1'b1;
    w_fdFl      = 1'b0;
    w_deFl      = 1'b0;
    w_emFl      = 1'b0;
    w_op        = SB_LOAD;
    w_iter_nxt  = '0;
    w_state_nxt = RUN;
    if (w_branch) begin
      w_fdFl = 1'b1;
      w_deFl = 1'b1;
      w_op   = SB_ADVANCE;
    end else if (w_vbusy) begin
      w_fdEn      = 1'b0;
      w_deEn      = 1'b0;
      w_emEn      = 1'b0;
      w_emFl      = 1'b1;
      w_op        = SB_HOLD;
      w_iter_nxt  = r_iter + 3'd1;
      w_state_nxt = VBUSY;
    end else if (w_raw) begin
      w_fdEn = 1'b0;
      w_deFl = 1'b1;
      w_op   = SB_ADVANCE;
    end else if (decValid_i && decVecOp_i && (N > 1)) begin
      w_state_nxt = VBUSY;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_state <= RUN;
      r_iter  <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_iter  <= w_iter_nxt;
    end
  end

  // Reset forces the bubble pattern on the outputs without waiting for a clock.
  assign fdEn_o    = ~rst_i & w_fdEn;
  assign deEn_o    = ~rst_i & w_deEn;
  assign emEn_o    = ~rst_i & w_emEn;
  assign mwEn_o    = ~rst_i & w_mwEn;
  assign fdFlush_o = rst_i | w_fdFl;
  assign deFlush_o = rst_i | w_deFl;
  assign emFlush_o = rst_i | w_emFl;
  assign exIter_o  = rst_i ? 3'd0 : r_iter;
  assign exLast_o  = ~rst_i & w_last;
  assign stall_o   = ~rst_i & ~w_fdEn;

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Scoreboard bench: each driven cycle queues its expected output bundle,
// a monitor pops and compares whenever the DUT outputs are sampled.
module tb_pipe_hazard_ctrl;

  logic       clk_i = 1'b0;
  logic       rst_i;
  logic       decValid_i;
  logic [3:0] decSrcS1_i, decSrcS2_i, decDstS_i;
  logic [1:0] decUseS_i, decUseV_i;
  logic [1:0] decSrcV1_i, decSrcV2_i, decDstV_i;
  logic       decWrS_i, decWrV_i, decVecOp_i, branchTaken_i;
  logic       fdEn_o, deEn_o, emEn_o, mwEn_o, fdFlush_o, deFlush_o, emFlush_o;
  logic [2:0] exIter_o;
  logic       exLast_o, stall_o;

  logic [11:0] q_exp[$];
  string       q_nm[$];
  int          n_chk = 0;
  int          n_fail = 0;

  always #5 clk_i = ~clk_i;

  pipe_hazard_ctrl dut (
    .clk_i(clk_i), .rst_i(rst_i), .decValid_i(decValid_i),
    .decSrcS1_i(decSrcS1_i), .decSrcS2_i(decSrcS2_i), .decUseS_i(decUseS_i),
    .decSrcV1_i(decSrcV1_i), .decSrcV2_i(decSrcV2_i), .decUseV_i(decUseV_i),
    .decDstS_i(decDstS_i), .decWrS_i(decWrS_i), .decDstV_i(decDstV_i), .decWrV_i(decWrV_i),
    .decVecOp_i(decVecOp_i), .branchTaken_i(branchTaken_i),
    .fdEn_o(fdEn_o), .deEn_o(deEn_o), .emEn_o(emEn_o), .mwEn_o(mwEn_o),
    .fdFlush_o(fdFlush_o), .deFlush_o(deFlush_o), .emFlush_o(emFlush_o),
    .exIter_o(exIter_o), .exLast_o(exLast_o), .stall_o(stall_o)
  );

  // {fdEn,deEn,emEn,mwEn, fdFl,deFl,emFl, iter, last, stall}
  function automatic logic [11:0] mk(input logic fd, input logic de, input logic em, input logic mw,
                                     input logic ff, input logic df, input logic ef,
                                     input logic [2:0] it, input logic la, input logic st);
    return {fd, de, em, mw, ff, df, ef, it, la, st};
  endfunction

  function automatic logic [11:0] n0();        return mk(1,1,1,1, 0,0,0, 3'd0, 0, 0); endfunction
  function automatic logic [11:0] nl();        return mk(1,1,1,1, 0,0,0, 3'd0, 1, 0); endfunction
  function automatic logic [11:0] rawc(input logic la); return mk(0,1,1,1, 0,1,0, 3'd0, la, 1); endfunction
  function automatic logic [11:0] vb(input logic [2:0] it); return mk(0,0,0,1, 0,0,1, it, 0, 1); endfunction
  function automatic logic [11:0] rst_exp();   return mk(0,0,0,0, 1,1,1, 3'd0, 0, 0); endfunction

  task automatic clr_dec();
    decValid_i = 0; decSrcS1_i = 0; decSrcS2_i = 0; decUseS_i = 0;
    decSrcV1_i = 0; decSrcV2_i = 0; decUseV_i = 0; decDstS_i = 0; decWrS_i = 0;
    decDstV_i = 0; decWrV_i = 0; decVecOp_i = 0; branchTaken_i = 0;
  endtask

  task automatic ins(input logic [1:0] us, input logic [3:0] s1, input logic [3:0] s2,
                     input logic [1:0] uv, input logic [1:0] v1, input logic [1:0] v2,
                     input logic ws, input logic [3:0] ds, input logic wv, input logic [1:0] dv,
                     input logic vec);
    clr_dec();
    decValid_i = 1; decUseS_i = us; decSrcS1_i = s1; decSrcS2_i = s2;
    decUseV_i = uv; decSrcV1_i = v1; decSrcV2_i = v2;
    decWrS_i = ws; decDstS_i = ds; decWrV_i = wv; decDstV_i = dv; decVecOp_i = vec;
  endtask

  task automatic step(input logic [11:0] e, input string nm);
    q_exp.push_back(e);
    q_nm.push_back(nm);
    @(posedge clk_i);
    #1;
  endtask

  // Monitor: samples one unit after the falling edge, or right after reset rises.
  initial begin
    logic [11:0] act, e;
    string nm;
    forever begin
      @(negedge clk_i or posedge rst_i);
      #1;
      if (q_exp.size() > 0) begin
        e   = q_exp.pop_front();
        nm  = q_nm.pop_front();
        act = {fdEn_o, deEn_o, emEn_o, mwEn_o, fdFlush_o, deFlush_o, emFlush_o,
               exIter_o, exLast_o, stall_o};
        n_chk++;
        if (act !== e) begin
          n_fail++;
          $display("FAIL %s: got %b expected %b (en fl iter last stall)", nm, act, e);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "timeout");
  end

  initial begin
    rst_i = 1;
    clr_dec();
    @(posedge clk_i);
    #1;
    step(rst_exp(), "reset_state");
    rst_i = 0; clr_dec();                             step(n0(), "first_run");

    // RAW with the producer in Execute: two bubbles
    ins(2'b00,0,0, 2'b00,0,0, 1,4'd3, 0,0, 0);        step(n0(), "t1_load_A");
    ins(2'b01,4'd3,0, 2'b00,0,0, 1,4'd4, 0,0, 0);     step(rawc(1), "t1_raw_E");
                                                      step(rawc(0), "t1_raw_M");
                                                      step(n0(), "t1_issue_B");
    clr_dec();                                        step(nl(), "t1_B_in_E");
                                                      step(n0(), "t1_drain");

    // RAW with the producer in Memory (vector); scalar S1 must not match V1
    ins(2'b00,0,0, 2'b00,0,0, 0,0, 1,2'd1, 0);        step(n0(), "t2_load_A");
    ins(2'b01,4'd1,0, 2'b00,0,0, 1,4'd5, 0,0, 0);     step(nl(), "t2_unrelated");
    ins(2'b00,0,0, 2'b01,2'd1,0, 0,0, 0,0, 0);        step(rawc(1), "t2_raw_M");
                                                      step(n0(), "t2_issue_C");
    clr_dec();                                        step(nl(), "t2_C_in_E");
                                                      step(n0(), "t2_drain");

    // Source matching both E and M: one two-bubble sequence
    ins(2'b00,0,0, 2'b00,0,0, 1,4'd3, 0,0, 0);        step(n0(), "t2b_load_A");
    ins(2'b00,0,0, 2'b00,0,0, 1,4'd3, 0,0, 0);        step(nl(), "t2b_load_A2");
    ins(2'b10,0,4'd3, 2'b00,0,0, 0,0, 0,0, 0);        step(rawc(1), "t2b_raw_EM");
                                                      step(rawc(0), "t2b_raw_M");
                                                      step(n0(), "t2b_issue");
    clr_dec();                                        step(nl(), "t2b_in_E");
                                                      step(n0(), "t2b_drain");

    // Vector iteration, with a branch flag raised mid-iteration
    ins(2'b00,0,0, 2'b00,0,0, 0,0, 1,2'd2, 1);        step(n0(), "t3_load_V");
    ins(2'b00,0,0, 2'b00,0,0, 1,4'd6, 0,0, 0);        step(vb(3'd0), "t3_iter0");
    branchTaken_i = 1;                                step(vb(3'd1), "t3_iter1_br_ignored");
    branchTaken_i = 0;                                step(mk(1,1,1,1, 0,0,0, 3'd2, 1, 0), "t3_iter2_last");
    clr_dec();                                        step(nl(), "t3_X_in_E");
                                                      step(n0(), "t3_drain");

    // Taken branch while Decode has a RAW on the branch's destination
    ins(2'b00,0,0, 2'b00,0,0, 1,4'd5, 0,0, 0);        step(n0(), "t4_load_br");
    ins(2'b10,0,4'd5, 2'b00,0,0, 1,4'd7, 0,0, 0);
    branchTaken_i = 1;                                step(mk(1,1,1,1, 1,1,0, 3'd0, 1, 0), "t4_branch_wins");
    ins(2'b01,4'd7,0, 2'b00,0,0, 0,0, 0,0, 0);        step(n0(), "t4_E_empty");
    clr_dec();                                        step(nl(), "t4_Z_in_E");
                                                      step(n0(), "t4_drain");

    // decValid_i low never raises raw
    ins(2'b00,0,0, 2'b00,0,0, 1,4'd9, 0,0, 0);        step(n0(), "t6_load_P");
    clr_dec(); decUseS_i = 2'b01; decSrcS1_i = 4'd9;  step(nl(), "t6_invalid_no_raw");
    clr_dec();                                        step(n0(), "t6_drain");

    // Asynchronous reset during a vector iteration
    ins(2'b00,0,0, 2'b00,0,0, 0,0, 1,2'd3, 1);        step(n0(), "t5_load_V");
    clr_dec();                                        step(vb(3'd0), "t5_iter0");
    q_exp.push_back(vb(3'd1)); q_nm.push_back("t5_iter1");
    @(negedge clk_i);
    #2;
    q_exp.push_back(rst_exp()); q_nm.push_back("t5_async_reset");
    rst_i = 1;
    @(posedge clk_i);
    #1;
                                                      step(rst_exp(), "t5_reset_held");
    rst_i = 0;                                        step(n0(), "t5_release_run");
                                                      step(n0(), "t5_still_run");

    repeat (2) @(posedge clk_i);
    n_chk++;
    if (q_exp.size() != 0) begin
      n_fail++;
      $display("FAIL drain: %0d expectations left unchecked, required 0", q_exp.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
